// File: rtl/eurorack_dsp_pkg.sv
// Shared types for the eurorack DSP blocks: channel count, channel index, smoother FSM states.
package eurorack_dsp_pkg;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    typedef logic [CH_W-1:0] ch_t;

    localparam ch_t LAST_CH = ch_t'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MUL    = 3'd2,
        ACC    = 3'd3,
        COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/one_pole_mac.sv
// Shared one-pole datapath: registered diff, registered product, combinational accumulate.
module one_pole_mac
    import eurorack_dsp_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = 8,
    parameter int unsigned F  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  mul,
    input  logic signed [W-1:0]   x,
    input  logic signed [W+F-1:0] s,
    input  logic [KW-1:0]         k,
    output logic signed [W+F-1:0] s_next_c
);

    localparam int unsigned SW = W + F;
    localparam int unsigned DW = SW + 1;
    localparam int unsigned PW = DW + KW + 1;

    logic signed [DW-1:0] diff_c;
    logic signed [DW-1:0] diff;
    logic signed [KW:0]   k_s_c;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh_c;
    logic signed [PW-1:0] sum_c;

    // Target minus state, one bit wider so it can never overflow.
    assign diff_c = $signed({x[W-1], x, {F{1'b0}}}) - $signed({s[SW-1], s});
    assign k_s_c  = $signed({1'b0, k});

    // Pipeline registers for the LOAD and MUL stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            diff <= '0;
            prod <= '0;
        end else begin
            if (load) begin
                diff <= diff_c;
            end
            if (mul) begin
                prod <= PW'(diff) * PW'(k_s_c);
            end
        end
    end

    // Step toward the target; k < 2^KW keeps the result inside the state range.
    assign prod_sh_c = prod >>> KW;
    assign sum_c     = PW'(s) + prod_sh_c;
    assign s_next_c  = sum_c[SW-1:0];

endmodule

// File: rtl/cv_smoother.sv
// Four-channel one-pole CV smoother sharing one multiplier, sequenced once per sample strobe.
// Optional build macro: CV_SMOOTHER_JACK_GATE_EN (unplugged channels bypass smoothing).
module cv_smoother
    import eurorack_dsp_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = 8,
    parameter int unsigned F  = 8
) (
    input  logic                clk_256fs,
    input  logic                rst,
    input  logic                strobe_fs,
    input  logic signed [W-1:0] in0,
    input  logic signed [W-1:0] in1,
    input  logic signed [W-1:0] in2,
    input  logic signed [W-1:0] in3,
    input  logic [KW-1:0]       coef0,
    input  logic [KW-1:0]       coef1,
    input  logic [KW-1:0]       coef2,
    input  logic [KW-1:0]       coef3,
    input  logic [7:0]          jack,
    output logic signed [W-1:0] out0,
    output logic signed [W-1:0] out1,
    output logic signed [W-1:0] out2,
    output logic signed [W-1:0] out3,
    output logic                out_valid,
    output logic                overrun
);

    localparam int unsigned SW = W + F;

    state_t state;
    state_t state_next;
    ch_t    ch;
    ch_t    ch_next;

    logic snap_c;
    logic load_c;
    logic mul_c;
    logic acc_c;
    logic commit_c;

    logic signed [W-1:0]  x_snap [N_CH];
    logic [KW-1:0]        k_snap [N_CH];
    logic signed [SW-1:0] s_q    [N_CH];
    logic signed [SW-1:0] s_next_c;
    logic signed [SW-1:0] s_upd_c;

    // State and channel counter registers.
    always_ff @(posedge clk_256fs) begin
        if (!rst) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
        end
    end

    // Next-state logic and per-stage enables.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        snap_c     = 1'b0;
        load_c     = 1'b0;
        mul_c      = 1'b0;
        acc_c      = 1'b0;
        commit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (strobe_fs) begin
                    snap_c     = 1'b1;
                    ch_next    = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_c     = 1'b1;
                state_next = MUL;
            end
            MUL: begin
                mul_c      = 1'b1;
                state_next = ACC;
            end
            ACC: begin
                acc_c = 1'b1;
                if (ch == LAST_CH) begin
                    state_next = COMMIT;
                end else begin
                    ch_next    = ch + ch_t'(1);
                    state_next = LOAD;
                end
            end
            COMMIT: begin
                commit_c   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Freeze inputs and coefficients for the whole pass.
    always_ff @(posedge clk_256fs) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                x_snap[i] <= '0;
                k_snap[i] <= '0;
            end
        end else if (snap_c) begin
            x_snap[0] <= in0;
            x_snap[1] <= in1;
            x_snap[2] <= in2;
            x_snap[3] <= in3;
            k_snap[0] <= coef0;
            k_snap[1] <= coef1;
            k_snap[2] <= coef2;
            k_snap[3] <= coef3;
        end
    end

    one_pole_mac #(
        .W  (W),
        .KW (KW),
        .F  (F)
    ) u_mac (
        .clk      (clk_256fs),
        .rst      (rst),
        .load     (load_c),
        .mul      (mul_c),
        .x        (x_snap[ch]),
        .s        (s_q[ch]),
        .k        (k_snap[ch]),
        .s_next_c (s_next_c)
    );

`ifdef CV_SMOOTHER_JACK_GATE_EN
    logic [N_CH-1:0] jack_snap;
    logic            unused_jack;

    assign unused_jack = ^jack[7:N_CH];

    // Jack flags are frozen together with the samples.
    always_ff @(posedge clk_256fs) begin
        if (!rst) begin
            jack_snap <= '0;
        end else if (snap_c) begin
            jack_snap <= jack[N_CH-1:0];
        end
    end

    // Unplugged channels jump straight to their (already zeroed) input.
    assign s_upd_c = jack_snap[ch] ? s_next_c : $signed({x_snap[ch], {F{1'b0}}});
`else
    logic unused_jack;

    assign unused_jack = ^jack;
    assign s_upd_c     = s_next_c;
`endif

    // Per-channel filter state, written in the ACC stage of its channel.
    always_ff @(posedge clk_256fs) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                s_q[i] <= '0;
            end
        end else if (acc_c) begin
            s_q[ch] <= s_upd_c;
        end
    end

    // All four outputs update together on COMMIT.
    always_ff @(posedge clk_256fs) begin
        if (!rst) begin
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= commit_c;
            if (commit_c) begin
                out0 <= s_q[0][SW-1:F];
                out1 <= s_q[1][SW-1:F];
                out2 <= s_q[2][SW-1:F];
                out3 <= s_q[3][SW-1:F];
            end
        end
    end

    // Sticky flag for strobes that arrive while a pass is in flight.
    always_ff @(posedge clk_256fs) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (strobe_fs && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv_smoother.sv
// Bench for cv_smoother: directed spec cases plus randomized passes against an arithmetic model.
module tb_cv_smoother;

    localparam int unsigned W  = 16;
    localparam int unsigned KW = 8;
    localparam int unsigned F  = 8;

`ifdef CV_SMOOTHER_JACK_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                strobe;
    logic signed [W-1:0] in_v   [4];
    logic [KW-1:0]       coef_v [4];
    logic [7:0]          jack;
    logic signed [W-1:0] out_v  [4];
    logic                out_valid;
    logic                overrun;

    int     checks = 0;
    int     fails  = 0;
    longint s_m [4];

    always #5 clk = ~clk;

    cv_smoother dut (
        .clk_256fs (clk),
        .rst       (rst),
        .strobe_fs (strobe),
        .in0       (in_v[0]),
        .in1       (in_v[1]),
        .in2       (in_v[2]),
        .in3       (in_v[3]),
        .coef0     (coef_v[0]),
        .coef1     (coef_v[1]),
        .coef2     (coef_v[2]),
        .coef3     (coef_v[3]),
        .jack      (jack),
        .out0      (out_v[0]),
        .out1      (out_v[1]),
        .out2      (out_v[2]),
        .out3      (out_v[3]),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: state moves by floor((target - state) * k / 256), target = x * 256.
    function automatic longint next_s(longint s, longint x, longint k, bit j);
        if (GATE && !j) return x * 256;
        return s + (((x * 256 - s) * k) >>> 8);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            s_m[i] = next_s(s_m[i], longint'(in_v[i]), longint'(coef_v[i]), jack[i]);
            chk($sformatf("s_range%0d", i),
                64'((s_m[i] >= -(64'sd1 <<< 23)) && (s_m[i] <= (64'sd1 <<< 23) - 1)), 64'd1);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) s_m[i] = 0;
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_out%0d", tag, i), 64'(out_v[i]), 64'(s_m[i] >>> 8));
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            in_v[i]   = W'($urandom);
            coef_v[i] = KW'($urandom);
        end
        jack = 8'($urandom);
    endtask

    // One full pass: strobe, bounded wait for out_valid, latency and single-pulse checks.
    task automatic run_pass(input string tag, input bit scramble);
        int n;
        model_step();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        if (scramble) rand_inputs();
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd14);
        check_outs(tag);
        tick();
        chk({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int          exp0 [5];
        int          exp1 [2];
        int          pulses;
        logic signed [W-1:0] prev3;

        exp0 = '{500, 750, 875, 937, 968};
        exp1 = '{-500, -750};

        rst    = 1'b0;
        strobe = 1'b0;
        jack   = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            in_v[i]   = '0;
            coef_v[i] = '0;
        end
        model_clear();

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("rst_out%0d", i), 64'(out_v[i]), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        tick();

        // Step, negative step, hold and fast-tracking channel together
        in_v[0] = 16'sd1000;   coef_v[0] = 8'd128;
        in_v[1] = -16'sd1000;  coef_v[1] = 8'd128;
        in_v[2] = 16'sd12345;  coef_v[2] = 8'd0;
        in_v[3] = 16'sd32767;  coef_v[3] = 8'd255;
        prev3 = '0;
        for (int p = 0; p < 5; p++) begin
            run_pass($sformatf("step%0d", p), 1'b0);
            chk($sformatf("step_out0_%0d", p), 64'(out_v[0]), 64'(exp0[p]));
            if (p < 2) chk($sformatf("neg_out1_%0d", p), 64'(out_v[1]), 64'(exp1[p]));
            chk($sformatf("hold_out2_%0d", p), 64'(out_v[2]), 64'd0);
            chk($sformatf("mono_out3_%0d", p), 64'(out_v[3] >= prev3), 64'd1);
            prev3 = out_v[3];
            repeat (240) tick();
        end
        chk("track_out3", 64'(out_v[3] >= 16'sd32766), 64'd1);
        chk("no_overrun", 64'(overrun), 64'd0);

        // Overrun: second strobe 5 cycles after the first is dropped
        model_step();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (4) tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("overrun_pulses", 64'(pulses), 64'd1);
        check_outs("overrun");

        // Reset at cycle 7 of a pass aborts it
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_clear();
        pulses = 0;
        repeat (30) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        chk("abort_pulses", 64'(pulses), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        check_outs("abort");
        run_pass("after_abort", 1'b0);
        chk("after_abort_out0", 64'(out_v[0]), 64'd500);

        // Jack gate: unplugged channel 0 with the slowest nonzero coefficient
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        model_clear();
        tick();
        jack      = 8'hFE;
        in_v[0]   = 16'sd2000;
        coef_v[0] = 8'd1;
        run_pass("jack", 1'b0);
        chk("jack_out0", 64'(out_v[0]), GATE ? 64'd2000 : 64'd7);

        // Randomized passes with inputs changed mid-pass
        for (int r = 0; r < 25; r++) begin
            rand_inputs();
            run_pass($sformatf("rand%0d", r), 1'b1);
            repeat ($urandom_range(0, 5)) tick();
        end
        chk("rand_no_overrun", 64'(overrun), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cv_smoother.md
Name: cv_smoother

Overview:
- Four-channel one-pole low-pass smoother (slew limiter) for calibrated CV/audio samples.
- Sits directly downstream of the PMOD driver's calibrated inputs `cal_in0..3`; its outputs feed the driver's `cal_out0..3`.
- Time-multiplexes one multiplier across the channels, sequenced by an FSM, once per sample strobe.
- Runs entirely in the `clk_256fs` domain, so there are ~256 cycles of budget per sample.

Parameters:
- W, 16, sample width in bits (signed).
- KW, 8, coefficient width in bits (unsigned fraction, k/2^KW).
- F, 8, extra fractional state bits per channel.

Ports:
- clk_256fs  input  1  sole clock.
- rst  input  1  synchronous reset, active-low (0 = reset).
- strobe_fs  input  1  one-cycle pulse per sample period, synchronous to clk_256fs.
- in0..in3  input  W  signed samples, connect to the driver's calibrated inputs.
- coef0..coef3  input  KW  per-channel smoothing coefficient. 0 = hold; larger = faster tracking.
- jack  input  8  jack-inserted flags; bit i = input i. Only bits 3:0 are used.
- out0..out3  output  W  signed smoothed samples, connect to the driver's calibrated outputs.
- out_valid  output  1  one-cycle pulse when out0..3 update.
- overrun  output  1  sticky flag: a strobe arrived while busy.

Behaviour:
- Reset (rst==0 on a clock edge):
  - out0..3 = 0, out_valid = 0, overrun = 0, all channel states = 0, FSM = IDLE.
  - A reset in any state aborts the sequence immediately; no partial commit.
- Channel state `s_i`: signed, W+F bits.
- Snapshot:
  - On strobe_fs in IDLE, latch in0..3, coef0..3 and jack[3:0] into snapshot registers.
  - Enter LOAD with channel counter ch = 0.
  - Later input changes do not affect the current pass.
- Per channel, three cycles:
  - LOAD: diff = (x_ch <<< F) - s_ch, W+F+1 bits signed. Register diff.
  - MUL: prod = diff * $signed({1'b0, k_ch}). Register prod.
  - ACC: s_ch <= s_ch + (prod >>> KW), arithmetic shift.
    - If ch == 3, go to COMMIT; otherwise ch++ and go to LOAD.
- COMMIT:
  - out_i <= s_i[W+F-1:F] for all four channels simultaneously.
  - out_valid = 1 for exactly this cycle.
  - Return to IDLE.
- Latency: a strobe at cycle t gives updated outputs and out_valid visible at t+14.
  - One cycle to leave IDLE, 12 channel cycles, one COMMIT cycle.
- Arithmetic bounds:
  - Because k < 2^KW, s_ch moves strictly toward the target and never overshoots, so no saturation is needed.
  - The bench asserts s_ch stays within [-2^(W+F-1), 2^(W+F-1)-1].
- Coefficient extremes:
  - k = 0 holds the state.
  - k = 2^KW-1 approaches the target within one LSB after several samples.
- strobe_fs outside IDLE: ignored, and overrun <= 1 (sticky until reset).
- strobe_fs coincident with the COMMIT cycle: also ignored and sets overrun.
- Outputs hold their value between commits.

Optional Feature:
- Macro: CV_SMOOTHER_JACK_GATE_EN.
- Defined:
  - In ACC, a channel with snapshot jack[ch] == 0 loads s_ch <= x_ch <<< F (bypass, no smoothing).
  - The calibration stage already zeroes unplugged inputs, so the output snaps to 0 instead of decaying.
- Undefined: the jack port is ignored; all channels always smooth.

Decomposition:
- Package `eurorack_dsp_pkg`:
  - N_CH = 4.
  - FSM state enum: IDLE, LOAD, MUL, ACC, COMMIT.
  - Channel index typedef (2 bits).
- Sub-module `one_pole_mac`: registered diff, multiply and accumulate datapath; parameters W, KW, F.
- Top-level `cv_smoother` contains the FSM, snapshot and state registers, and output registers.

Test Plan:
- Reset with rst=0 for 3 cycles -> out0..3 = 0, out_valid = 0, overrun = 0. Release, then strobe -> out_valid exactly 14 cycles after the strobe.
- Step response: in0 = 1000, coef0 = 128 (KW=8, F=8), five strobes 256 cycles apart -> out0 = 500, 750, 875, 937, 968.
- Negative step: in1 = -1000, coef1 = 128 -> out1 = -500, -750.
- Hold: coef2 = 0, in2 = 12345 -> out2 stays at 0.
- Channel independence: coef3 = 255 with in3 = 32767 -> out3 approaches 32767, never exceeds it, no wrap.
- Overrun: second strobe 5 cycles after the first -> overrun = 1, and only one out_valid pulse. Assert rst=0 mid-pass (cycle 7) -> no out_valid, outputs 0, overrun cleared.
- CV_SMOOTHER_JACK_GATE_EN defined: jack[0] = 0, in0 = 2000, coef0 = 1 -> out0 = 2000 after the first pass. With the macro undefined, the same stimulus gives out0 = 7.
